// File: rtl/multicycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg -- shared definitions for the multicycle instruction sequencer.
//
// Contents:
//   SEQ_XLEN      default PC / address / instruction width
//   SEQ_RESET_PC  default PC loaded while reset is asserted
//   SEQ_NOP       canonical NOP encoding (addi x0, x0, 0)
//   SEQ_WAIT_W    width of the memory-acknowledge wait counter (TIMEOUT <= 255)
//   seq_state_e   sequencer states
//   pc_aligned()  word-alignment test for a candidate PC
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int          SEQ_XLEN     = 32;
    localparam logic [31:0] SEQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SEQ_NOP      = 32'h0000_0013;
    localparam int          SEQ_WAIT_W   = 8;

    // Explicit codes so an unused encoding can be steered to ERROR.
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_e;

    // A PC is usable only when it is word aligned.
    function automatic logic pc_aligned(input logic [1:0] pc_lo);
        return (pc_lo == 2'b00);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer -- counts cycles spent waiting for a memory acknowledge and flags
// the cycle in which the wait budget is exhausted.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset (counter -> 0)
//   i_clr      synchronous clear, asserted on every state change of the owner
//   i_en       owner is in a state that waits for an acknowledge
//   i_ack      the acknowledge the owner is waiting for
//   o_expired  counter sits at TIMEOUT and no acknowledge this cycle
// -----------------------------------------------------------------------------
module wait_timer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_ack,
    output logic o_expired
);

    logic [SEQ_WAIT_W-1:0] r_count;
    logic                  w_at_limit;

    assign w_at_limit = (r_count == SEQ_WAIT_W'(TIMEOUT));

    // Wait counter: cleared on state change, advanced on every unacknowledged
    // waiting cycle, parked at the limit so it can never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {SEQ_WAIT_W{1'b0}};
        end else if (i_clr) begin
            r_count <= {SEQ_WAIT_W{1'b0}};
        end else if (i_en && !i_ack && !w_at_limit) begin
            r_count <= r_count + SEQ_WAIT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // An acknowledge arriving in the limit cycle takes priority over expiry.
    assign o_expired = i_en && !i_ack && w_at_limit;

endmodule

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer -- FETCH / EXEC / MEM / WB control sequencer for a
// multicycle processor, with acknowledge timeouts and a sticky ERROR state.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   imem_req    instruction fetch request (FETCH)
//   imem_addr   fetch address, equals pc_o
//   imem_ack    fetch data valid (honoured only in FETCH)
//   imem_rdata  fetched instruction
//   is_mem      instruction in ir_o is a load/store (sampled in EXEC)
//   dmem_req    data memory access enable (MEM)
//   dmem_ack    data access complete (honoured only in MEM)
//   next_pc_i   next PC from the datapath (taken in WB)
//   ir_o        instruction register
//   pc_o        current PC
//   reg_commit  register-file write gate (WB)
//   retire      one pulse per completed instruction
//   instret     retired-instruction counter, wraps silently
//   err         sticky fault flag (ERROR), cleared only by reset
// -----------------------------------------------------------------------------
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int              XLEN     = SEQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(SEQ_RESET_PC),
    parameter int              TIMEOUT  = 15,
    parameter int              RET_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             is_mem,
    output logic             dmem_req,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  next_pc_i,
    output logic [XLEN-1:0]  ir_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             reg_commit,
    output logic             retire,
    output logic [RET_W-1:0] instret,
    output logic             err
);

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_ir;
    logic [RET_W-1:0]  r_instret;

    logic w_in_fetch;
    logic w_in_mem;
    logic w_in_wb;
    logic w_wait_en;
    logic w_wait_ack;
    logic w_wait_clr;
    logic w_expired;
    logic w_pc_ok;
    logic w_fetch_done;
    logic w_retire;

    assign w_in_fetch   = (r_state == ST_FETCH);
    assign w_in_mem     = (r_state == ST_MEM);
    assign w_in_wb      = (r_state == ST_WB);
    assign w_pc_ok      = pc_aligned(next_pc_i[1:0]);
    assign w_fetch_done = w_in_fetch && imem_ack;
    assign w_retire     = w_in_wb && w_pc_ok;

    // Only the acknowledge matching the current state counts; strays are ignored.
    assign w_wait_en  = w_in_fetch || w_in_mem;
    assign w_wait_ack = (w_in_fetch && imem_ack) || (w_in_mem && dmem_ack);
    // Any state change clears the timer, so it starts at zero on entry to FETCH/MEM.
    assign w_wait_clr = (w_next_state != r_state);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr     (w_wait_clr),
        .i_en      (w_wait_en),
        .i_ack     (w_wait_ack),
        .o_expired (w_expired)
    );

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack) begin
                    w_next_state = ST_EXEC;
                end else if (w_expired) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (is_mem) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    w_next_state = ST_WB;
                end else if (w_expired) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_next_state = ST_MEM;
                end
            end
            ST_WB: begin
                if (w_pc_ok) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_ERROR: begin
                w_next_state = ST_ERROR;
            end
            default: begin
                w_next_state = ST_ERROR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction register: captured when the fetch completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir <= {XLEN{1'b0}};
        end else if (w_fetch_done) begin
            r_ir <= imem_rdata;
        end else begin
            r_ir <= r_ir;
        end
    end

    // PC and retire counter advance only on a clean write-back; a misaligned
    // next PC leaves both untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_instret <= {RET_W{1'b0}};
        end else if (w_retire) begin
            r_pc      <= next_pc_i;
            r_instret <= r_instret + RET_W'(1);
        end else begin
            r_pc      <= r_pc;
            r_instret <= r_instret;
        end
    end

    // Fetch request is also gated by rst so it drops the instant reset asserts,
    // even though the state register then reads FETCH.
    assign imem_req   = w_in_fetch && rst;
    assign imem_addr  = r_pc;
    assign dmem_req   = w_in_mem;
    // reg_commit stays up in WB even for a bad next PC; retire needs a good one.
    assign reg_commit = w_in_wb;
    assign retire     = w_retire;
    assign err        = (r_state == ST_ERROR);
    assign ir_o       = r_ir;
    assign pc_o       = r_pc;
    assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for multicycle_sequencer (TIMEOUT=4, RET_W=4).
// An instruction-level reference model predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TO       = 4;
    localparam int          RET_W    = 4;

    // What the modelled sequencer is currently doing.
    localparam int M_WAIT_INSN = 0;
    localparam int M_DECODE    = 1;
    localparam int M_WAIT_DATA = 2;
    localparam int M_COMMIT    = 3;
    localparam int M_HALTED    = 4;

    logic             clk;
    logic             rst;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ack;
    logic [XLEN-1:0]  imem_rdata;
    logic             is_mem;
    logic             dmem_req;
    logic             dmem_ack;
    logic [XLEN-1:0]  next_pc_i;
    logic [XLEN-1:0]  ir_o;
    logic [XLEN-1:0]  pc_o;
    logic             reg_commit;
    logic             retire;
    logic [RET_W-1:0] instret;
    logic             err;

    int total = 0;
    int bad   = 0;

    int          m_phase;
    int          m_waited;
    int          m_retired;
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    multicycle_sequencer #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TO),
        .RET_W    (RET_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .is_mem     (is_mem),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .next_pc_i  (next_pc_i),
        .ir_o       (ir_o),
        .pc_o       (pc_o),
        .reg_commit (reg_commit),
        .retire     (retire),
        .instret    (instret),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = M_WAIT_INSN;
        m_waited  = 0;
        m_retired = 0;
        m_pc      = RESET_PC;
        m_ir      = 32'h0;
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (m_phase == M_WAIT_INSN) begin
            if (imem_ack) begin
                m_ir    = imem_rdata;
                m_phase = M_DECODE;
            end else if (m_waited == TO) begin
                m_phase = M_HALTED;
            end else begin
                m_waited++;
            end
        end else if (m_phase == M_DECODE) begin
            m_waited = 0;
            m_phase  = is_mem ? M_WAIT_DATA : M_COMMIT;
        end else if (m_phase == M_WAIT_DATA) begin
            if (dmem_ack) begin
                m_phase = M_COMMIT;
            end else if (m_waited == TO) begin
                m_phase = M_HALTED;
            end else begin
                m_waited++;
            end
        end else if (m_phase == M_COMMIT) begin
            if (next_pc_i[1:0] == 2'b00) begin
                m_pc      = next_pc_i;
                m_retired = (m_retired + 1) % (1 << RET_W);
                m_waited  = 0;
                m_phase   = M_WAIT_INSN;
            end else begin
                m_phase = M_HALTED;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req",   32'(imem_req),   32'(rst && (m_phase == M_WAIT_INSN)));
        chk("imem_addr",  imem_addr,       m_pc);
        chk("pc_o",       pc_o,            m_pc);
        chk("ir_o",       ir_o,            m_ir);
        chk("dmem_req",   32'(dmem_req),   32'(m_phase == M_WAIT_DATA));
        chk("reg_commit", 32'(reg_commit), 32'(m_phase == M_COMMIT));
        chk("retire",     32'(retire),     32'((m_phase == M_COMMIT) && (next_pc_i[1:0] == 2'b00)));
        chk("instret",    32'(instret),    32'(m_retired));
        chk("err",        32'(err),        32'(m_phase == M_HALTED));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Assert reset in mid-cycle (away from any edge) and check right away.
    task automatic reset_assert();
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_imem_req_low", 32'(imem_req), 32'd0);
        chk("rst_dmem_req_low", 32'(dmem_req), 32'd0);
        chk("rst_pc",           pc_o,          RESET_PC);
        chk("rst_err",          32'(err),      32'd0);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b1;
        #1;
        compare_all();
        chk("first_imem_req", 32'(imem_req), 32'd1);
    endtask

    task automatic do_reset();
        reset_assert();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        is_mem   = 1'b0;
        repeat (2) cycle();
        reset_release();
    endtask

    initial begin
        int ret_cnt;
        int dmem_hi;
        int commits;
        int retire_at;
        int halted_for;
        int r;

        rst        = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        is_mem     = 1'b0;
        imem_rdata = 32'h0;
        next_pc_i  = 32'h4;
        model_reset();
        @(negedge clk);
        compare_all();
        chk("reset_ir",      ir_o,          32'h0);
        chk("reset_instret", 32'(instret),  32'd0);
        chk("reset_err",     32'(err),      32'd0);
        chk("reset_imem_req",32'(imem_req), 32'd0);
        repeat (2) cycle();
        reset_release();

        // Back-to-back non-memory instructions: 3 cycles each.
        imem_ack = 1'b1;
        is_mem   = 1'b0;
        ret_cnt  = 0;
        for (int i = 0; i < 9; i++) begin
            next_pc_i  = m_pc + 32'd4;
            imem_rdata = $urandom;
            cycle();
            if (retire) begin
                ret_cnt++;
                chk("seq_pc_at_retire", pc_o, 32'(4 * (ret_cnt - 1)));
            end
        end
        chk("seq_retire_count", 32'(ret_cnt),  32'd3);
        chk("seq_instret",      32'(instret),  32'd3);
        chk("seq_pc_after",     pc_o,          32'd12);

        // Memory instruction, data acknowledge after two wait cycles.
        is_mem    = 1'b1;
        dmem_hi   = 0;
        commits   = 0;
        retire_at = 0;
        for (int i = 0; i < 6; i++) begin
            next_pc_i  = m_pc + 32'd4;
            imem_rdata = $urandom;
            dmem_ack   = (m_phase == M_WAIT_DATA) && (m_waited == 2);
            cycle();
            if (dmem_req)   dmem_hi++;
            if (reg_commit) commits++;
            if (retire)     retire_at = i + 2;
        end
        chk("mem_dmem_req_cycles", 32'(dmem_hi),   32'd3);
        chk("mem_commits",         32'(commits),   32'd1);
        chk("mem_retire_cycle",    32'(retire_at), 32'd6);

        // Data acknowledge exactly when the wait counter reaches TIMEOUT.
        dmem_hi = 0;
        ret_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            next_pc_i  = m_pc + 32'd4;
            imem_rdata = $urandom;
            dmem_ack   = (m_phase == M_WAIT_DATA) && (m_waited == TO);
            cycle();
            if (dmem_req) dmem_hi++;
            if (retire)   ret_cnt++;
        end
        chk("lastack_dmem_cycles", 32'(dmem_hi), 32'd5);
        chk("lastack_retired",     32'(ret_cnt), 32'd1);
        chk("lastack_err",         32'(err),     32'd0);
        dmem_ack = 1'b0;
        is_mem   = 1'b0;

        // 16 retirements wrap the 4-bit counter.
        do_reset();
        imem_ack = 1'b1;
        ret_cnt  = 0;
        for (int i = 0; i < 48; i++) begin
            next_pc_i  = m_pc + 32'd4;
            imem_rdata = $urandom;
            cycle();
            if (retire) ret_cnt++;
        end
        chk("wrap_retired", 32'(ret_cnt), 32'd16);
        chk("wrap_instret", 32'(instret), 32'd0);
        chk("wrap_err",     32'(err),     32'd0);
        chk("wrap_pc",      pc_o,         32'd64);

        // Reset in the middle of a data access.
        is_mem = 1'b1;
        repeat (2) begin
            next_pc_i = m_pc + 32'd4;
            cycle();
        end
        chk("midmem_dmem_req", 32'(dmem_req), 32'd1);
        reset_assert();
        is_mem = 1'b0;
        repeat (2) cycle();
        reset_release();

        // Fetch acknowledge never comes: ERROR after TIMEOUT wait cycles.
        imem_ack = 1'b0;
        repeat (4) cycle();
        chk("to_err_before",      32'(err),      32'd0);
        chk("to_imem_req_before", 32'(imem_req), 32'd1);
        cycle();
        chk("to_err",      32'(err),      32'd1);
        chk("to_imem_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (5) cycle();
        chk("to_err_sticky", 32'(err), 32'd1);
        dmem_ack = 1'b0;
        reset_assert();
        imem_ack = 1'b0;
        repeat (2) cycle();
        reset_release();

        // Misaligned next PC at write-back.
        imem_ack  = 1'b1;
        is_mem    = 1'b0;
        next_pc_i = 32'h0000_0006;
        repeat (2) cycle();
        chk("mis_commit", 32'(reg_commit), 32'd1);
        chk("mis_retire", 32'(retire),     32'd0);
        cycle();
        chk("mis_err",     32'(err),     32'd1);
        chk("mis_pc",      pc_o,         RESET_PC);
        chk("mis_instret", 32'(instret), 32'd0);

        // Randomized episodes.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            halted_for = 0;
            for (int c = 0; c < 400; c++) begin
                imem_ack   = ($urandom_range(0, 9) < 6);
                dmem_ack   = ($urandom_range(0, 9) < 5);
                is_mem     = $urandom_range(0, 1) == 1;
                imem_rdata = $urandom;
                r = $urandom_range(0, 63);
                if (r == 0) begin
                    next_pc_i = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                end else if (r < 8) begin
                    next_pc_i = $urandom & 32'hFFFF_FFFC;
                end else begin
                    next_pc_i = m_pc + 32'd4;
                end
                cycle();
                halted_for = (m_phase == M_HALTED) ? halted_for + 1 : 0;
                if (halted_for > 8) begin
                    do_reset();
                    halted_for = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
